// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and the ShiftRows index helper for
// the iterative SubBytes + ShiftRows stage.
package aes_pkg;

  localparam int unsigned AES_NB     = 4;
  localparam int unsigned AES_BYTE_W = 8;
  localparam int unsigned AES_COL_W  = AES_NB * AES_BYTE_W;
  localparam int unsigned AES_BLK_W  = AES_NB * AES_COL_W;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] AES_GF_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Source column for output byte (row, col): forward ShiftRows reads
  // column (col + row) mod 4, InvShiftRows reads (col - row) mod 4.
  // The 2-bit arithmetic supplies the mod 4 wrap.
  function automatic logic [1:0] shift_src_col(input logic [1:0] row,
                                               input logic [1:0] col,
                                               input logic       inv);
    logic [1:0] src;
    src = inv ? (col - row) : (col + row);
    return src;
  endfunction

endpackage

// File: rtl/sub_shift_rows_iter_if.sv
// Handshake/data bundle for sub_shift_rows_iter.
// Optional build macro: AES_INV_SUBSHIFT_EN adds the i_inv mode select.
interface sub_shift_rows_iter_if;
  import aes_pkg::*;

  logic                 i_valid;
  logic                 o_ready;
  logic [AES_BLK_W-1:0] i_block;
  logic                 o_valid;
  logic                 i_ready;
  logic [AES_BLK_W-1:0] o_block;
`ifdef AES_INV_SUBSHIFT_EN
  logic                 i_inv;
`endif

`ifdef AES_INV_SUBSHIFT_EN
  modport master (output i_valid, i_block, i_ready, i_inv,
                  input  o_ready, o_valid, o_block);
  modport slave  (input  i_valid, i_block, i_ready, i_inv,
                  output o_ready, o_valid, o_block);
`else
  modport master (output i_valid, i_block, i_ready,
                  input  o_ready, o_valid, o_block);
  modport slave  (input  i_valid, i_block, i_ready,
                  output o_ready, o_valid, o_block);
`endif

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse followed by the affine transform.
// Optional build macro: AES_INV_SUBSHIFT_EN adds i_inv, selecting the
// inverse S-box (inverse affine first, then the field inverse).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] i_byte,
`ifdef AES_INV_SUBSHIFT_EN
  input  logic                  i_inv,
`endif
  output logic [AES_BYTE_W-1:0] o_byte
);

  // Shift-and-add multiply, reducing by the field polynomial on each shift.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? AES_GF_POLY : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] acc;
    logic [7:0] sq;
    acc = 8'h01;
    sq  = x;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
             ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

`ifdef AES_INV_SUBSHIFT_EN
  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  endfunction
`endif

  // Byte substitution, forward or inverse depending on the build and mode.
  always_comb begin
    o_byte = affine(gf_inv(i_byte));
`ifdef AES_INV_SUBSHIFT_EN
    if (i_inv) o_byte = gf_inv(inv_affine(i_byte));
`endif
  end

endmodule

// File: rtl/sub_shift_rows_iter.sv
// Iterative SubBytes + ShiftRows: one column per cycle through four shared
// S-boxes, then the (Inv)ShiftRows permutation as wiring on the register.
// Optional build macro: AES_INV_SUBSHIFT_EN adds i_inv (latched on accept)
// selecting inverse S-box + InvShiftRows.
module sub_shift_rows_iter
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  sub_shift_rows_iter_if.slave bus
);

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [AES_BLK_W-1:0] data_q, data_d;
  logic                 inv_q, inv_d;

  logic                 accept;
  logic                 in_inv;
  logic [AES_COL_W-1:0] col_in;
  logic [AES_COL_W-1:0] col_sub;
  logic [AES_BLK_W-1:0] blk_out;

`ifdef AES_INV_SUBSHIFT_EN
  assign in_inv = bus.i_inv;
`else
  assign in_inv = 1'b0;
`endif

  // Column currently being substituted.
  always_comb begin
    col_in = '0;
    for (int unsigned c = 0; c < AES_NB; c++) begin
      if (cnt_q == 2'(c)) col_in = data_q[AES_BLK_W-1-AES_COL_W*c -: AES_COL_W];
    end
  end

  // One S-box per row of the active column.
  for (genvar r = 0; r < AES_NB; r++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (col_in[AES_COL_W-1-AES_BYTE_W*r -: AES_BYTE_W]),
`ifdef AES_INV_SUBSHIFT_EN
      .i_inv  (inv_q),
`endif
      .o_byte (col_sub[AES_COL_W-1-AES_BYTE_W*r -: AES_BYTE_W])
    );
  end

  // Handshake outputs; o_ready sees i_ready combinationally in DONE so a
  // finished block can be handed off and a new one taken in the same edge.
  always_comb begin
    bus.o_valid = (state_q == DONE);
    bus.o_ready = (state_q == IDLE) || ((state_q == DONE) && bus.i_ready);
  end

  // Next-state, column counter and data register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    inv_d   = inv_q;
    accept  = bus.i_valid &&
              ((state_q == IDLE) || ((state_q == DONE) && bus.i_ready));
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          data_d  = bus.i_block;
          cnt_d   = '0;
          inv_d   = in_inv;
          state_d = BUSY;
        end else if ((state_q == DONE) && bus.i_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        for (int unsigned c = 0; c < AES_NB; c++) begin
          if (cnt_q == 2'(c)) data_d[AES_BLK_W-1-AES_COL_W*c -: AES_COL_W] = col_sub;
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      inv_q   <= inv_d;
    end
  end

  // (Inv)ShiftRows permutation of the registered data.
  always_comb begin
    blk_out = '0;
    for (int unsigned r = 0; r < AES_NB; r++) begin
      for (int unsigned c = 0; c < AES_NB; c++) begin
        blk_out[AES_BLK_W-1-AES_COL_W*c-AES_BYTE_W*r -: AES_BYTE_W] =
          data_q[AES_BLK_W-1-AES_COL_W*shift_src_col(2'(r), 2'(c), inv_q)
                 -AES_BYTE_W*r -: AES_BYTE_W];
      end
    end
  end

  assign bus.o_block = blk_out;

endmodule
